// File: rtl/disp_scanout.sv
// disp_scanout: fetches one W*H frame per frame_start from the front buffer and
//   streams it to the panel timing generator.
// Latency: first pixel appears one cycle after its read data returns (first-word fall-through FIFO).
// Backpressure: read requests are credit-limited so that FIFO words plus outstanding reads
//   never exceed DEPTH; pix_ready low simply holds the FIFO head.
// Ports:
//   clkSYS, n_reset           clock, asynchronous active-low reset
//   frame_start, stat         frame trigger pulse, front-buffer select
//   mem_addr/req/wr/ack       arbiter read request channel (mem_wr tied low)
//   mem_valid, mem_data       in-order read data return
//   pix_valid/ready/data      pixel stream to the timing generator
//   frame_done, underrun      last-pixel pulse, sticky starvation flag
module disp_scanout #(
  parameter int unsigned AN    = 24,
  parameter int unsigned DN    = 16,
  parameter int unsigned BASE  = 0,
  parameter int unsigned SWAP  = 0,
  parameter int unsigned W     = 800,
  parameter int unsigned H     = 480,
  parameter int unsigned DEPTH = 32
) (
  input  logic          clkSYS,
  input  logic          n_reset,
  input  logic          frame_start,
  input  logic          stat,
  output logic [AN-1:0] mem_addr,
  output logic          mem_req,
  output logic          mem_wr,
  input  logic          mem_ack,
  input  logic          mem_valid,
  input  logic [DN-1:0] mem_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [DN-1:0] pix_data,
  output logic          frame_done,
  output logic          underrun
);

  localparam int unsigned NPIX = W * H;
  localparam int unsigned CW   = $clog2(NPIX + 1);
  localparam int unsigned FW   = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST   = CW'(NPIX - 1);
  localparam logic [AN-1:0] BASE_A = AN'(BASE);
  localparam logic [AN-1:0] SWAP_A = AN'(SWAP);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE, S_FLUSH} state_t;

  state_t        state_q;
  logic [AN-1:0] addr_q;
  logic [CW-1:0] reqcnt_q, popcnt_q;
  logic [FW:0]   outst_q, outst_d;
  logic [FW:0]   count_q, count_d;
  logic [FW-1:0] wp_q, rp_q;
  logic [DN-1:0] fifo_q [DEPTH];
  logic          underrun_q;

  logic          active, credit_ok, acc, rtn, push, pop, last_pop, abort, start;
  logic [FW+1:0] used;
  logic [AN-1:0] start_addr;

  always_comb begin
    active     = (state_q == S_FETCH) || (state_q == S_DONE);
    used       = {1'b0, count_q} + {1'b0, outst_q};
    credit_ok  = used < (FW+2)'(DEPTH);
    mem_req    = (state_q == S_FETCH) && credit_ok;
    acc        = mem_req && mem_ack;
    rtn        = mem_valid && (outst_q != '0);
    // Returns arriving while flushing belong to the aborted frame and are dropped.
    push       = rtn && active;
    pix_valid  = (count_q != '0);
    pop        = active && pix_valid && pix_ready;
    abort      = active && frame_start;
    last_pop   = (state_q == S_DONE) && pop && (popcnt_q == LAST);
    // A frame_start landing on the last pop aborts instead: no completion is reported.
    frame_done = last_pop && !frame_start;
    // Flush only exits once every stale read has drained.
    start      = ((state_q == S_IDLE) && frame_start) ||
                 ((state_q == S_FLUSH) && (outst_q == '0));
    start_addr = BASE_A + (stat ? SWAP_A : '0);
    outst_d    = outst_q + (FW+1)'(acc) - (FW+1)'(rtn);
    count_d    = abort ? '0 : (count_q + (FW+1)'(push) - (FW+1)'(pop));
  end

  assign mem_addr = addr_q;
  assign mem_wr   = 1'b0;
  assign pix_data = pix_valid ? fifo_q[rp_q] : '0;
  assign underrun = underrun_q;

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      reqcnt_q <= '0;
      popcnt_q <= '0;
    end else begin
      if (pop) popcnt_q <= popcnt_q + CW'(1);
      case (state_q)
        S_IDLE, S_FLUSH: begin
          if (start) begin
            state_q  <= S_FETCH;
            addr_q   <= start_addr;
            reqcnt_q <= '0;
            popcnt_q <= '0;
          end
        end
        S_FETCH: begin
          if (acc) begin
            addr_q   <= addr_q + AN'(1);
            reqcnt_q <= reqcnt_q + CW'(1);
          end
          if (frame_start)                state_q <= S_FLUSH;
          else if (acc && reqcnt_q == LAST) state_q <= S_DONE;
        end
        S_DONE: begin
          if (frame_start)   state_q <= S_FLUSH;
          else if (last_pop) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      outst_q    <= '0;
      count_q    <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      underrun_q <= 1'b0;
    end else begin
      outst_q <= outst_d;
      count_q <= count_d;
      if (abort) begin
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        if (push) wp_q <= wp_q + FW'(1);
        if (pop)  rp_q <= rp_q + FW'(1);
      end
      if (active && pix_ready && !pix_valid) underrun_q <= 1'b1;
    end
  end

  // Storage needs no reset: pix_data is masked while the FIFO is empty.
  always_ff @(posedge clkSYS) begin
    if (push) fifo_q[wp_q] <= mem_data;
  end

endmodule

// File: tb/tb_disp_scanout.sv
module tb_disp_scanout;
  localparam int NPIX  = 8;
  localparam int DEPTH = 4;

  logic        clk;
  logic        n_reset, frame_start, stat, mem_ack, mem_valid, pix_ready;
  logic [15:0] mem_data, pix_data;
  logic [23:0] mem_addr;
  logic        mem_req, mem_wr, pix_valid, frame_done, underrun;

  disp_scanout #(.AN(24), .DN(16), .BASE('h100), .SWAP('h800), .W(4), .H(2), .DEPTH(4)) dut (
    .clkSYS(clk), .n_reset(n_reset), .frame_start(frame_start), .stat(stat),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_wr(mem_wr), .mem_ack(mem_ack),
    .mem_valid(mem_valid), .mem_data(mem_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_data(pix_data), .frame_done(frame_done),
    .underrun(underrun));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [15:0] d; } rd_t;
  rd_t pend[$];

  typedef struct {
    logic        st;
    int          lat, ack_pct, vld_pct, rdy_mode;
    logic [23:0] base;
    logic        exp_unr;
  } vec_t;
  vec_t tbl[7];

  int checks, errors, cyc;
  int lat, ack_pct, vld_pct, rdy_mode, rdy_pct;
  int req_idx, pop_idx, req_cnt, done_cnt, fifo_m, outst_m, old_outst;
  logic [23:0] exp_base, nxt_base;
  logic        fs_next;

  function automatic logic [15:0] pdat(input logic [23:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs at negedge, observe just after, account the cycle's events.
  task automatic tick();
    rd_t r;
    logic popped;
    @(negedge clk);
    frame_start = fs_next;
    fs_next     = 1'b0;
    mem_valid   = 1'b0;
    mem_data    = '0;
    if (pend.size() > 0 && pend[0].due <= cyc && int'($urandom_range(99)) < vld_pct) begin
      r         = pend.pop_front();
      mem_valid = 1'b1;
      mem_data  = r.d;
    end
    mem_ack = mem_req && (int'($urandom_range(99)) < ack_pct);
    case (rdy_mode)
      0:       pix_ready = 1'b0;
      1:       pix_ready = 1'b1;
      2:       pix_ready = pix_valid;
      default: pix_ready = int'($urandom_range(99)) < rdy_pct;
    endcase
    #1;
    chk("pix_valid", 32'(pix_valid), 32'(fifo_m != 0));
    if (mem_req && mem_ack) begin
      chk("credit", 32'(fifo_m + outst_m < DEPTH), 32'd1);
      chk("req_addr", 32'(mem_addr), 32'(exp_base + 24'(req_idx)));
      r.due = cyc + lat;
      r.d   = pdat(mem_addr);
      pend.push_back(r);
      req_idx++; req_cnt++; outst_m++;
    end
    if (mem_valid) begin
      outst_m--;
      if (old_outst > 0) old_outst--;
      else               fifo_m++;
    end
    popped = pix_valid && pix_ready;
    if (popped) begin
      chk("pix_data", 32'(pix_data), 32'(pdat(exp_base + 24'(pop_idx))));
      pop_idx++;
      fifo_m--;
    end
    if (frame_done) begin
      done_cnt++;
      chk("done_at_last", 32'(popped && pop_idx == NPIX), 32'd1);
    end
    if (frame_start) begin
      old_outst = outst_m;
      fifo_m    = 0;
      req_idx   = 0;
      pop_idx   = 0;
      exp_base  = nxt_base;
    end
    cyc++;
  endtask

  task automatic run_frame(input logic st, input logic [23:0] base);
    int d0;
    stat     = st;
    nxt_base = base;
    fs_next  = 1'b1;
    req_cnt  = 0;
    d0       = done_cnt;
    for (int i = 0; i < 4000 && done_cnt == d0; i++) tick();
    chk("frame_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("frame_reqs", 32'(req_cnt), 32'(NPIX));
    chk("frame_pops", 32'(pop_idx), 32'(NPIX));
    tick();
    chk("idle_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    int d0;
    logic s;
    tbl[0] = '{1'b0, 2, 100, 100, 2, 24'h000100, 1'b0};
    tbl[1] = '{1'b1, 2, 100, 100, 2, 24'h000900, 1'b0};
    tbl[2] = '{1'b0, 1,  50,  50, 2, 24'h000100, 1'b0};
    tbl[3] = '{1'b1, 3,  70,  40, 2, 24'h000900, 1'b0};
    tbl[4] = '{1'b0, 10, 100, 100, 1, 24'h000100, 1'b1};
    tbl[5] = '{1'b1, 2, 100, 100, 2, 24'h000900, 1'b1};
    tbl[6] = '{1'b0, 2, 100, 100, 1, 24'h000100, 1'b1};

    checks = 0; errors = 0; cyc = 0;
    lat = 2; ack_pct = 100; vld_pct = 100; rdy_mode = 0; rdy_pct = 50;
    req_idx = 0; pop_idx = 0; req_cnt = 0; done_cnt = 0;
    fifo_m = 0; outst_m = 0; old_outst = 0;
    exp_base = 24'h100; nxt_base = 24'h100; fs_next = 1'b0;
    n_reset = 1'b0; frame_start = 1'b0; stat = 1'b0;
    mem_ack = 1'b0; mem_valid = 1'b0; mem_data = '0; pix_ready = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wr", 32'(mem_wr), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    n_reset = 1'b1;
    tick();

    // Consumer stalled: exactly DEPTH requests, then request line drops
    rdy_mode = 0; stat = 1'b0; nxt_base = 24'h100; fs_next = 1'b1; req_cnt = 0; d0 = done_cnt;
    for (int i = 0; i < 30; i++) tick();
    chk("bp_reqs", 32'(req_cnt), 32'd4);
    chk("bp_req_low", 32'(mem_req), 32'd0);
    chk("bp_pix_valid", 32'(pix_valid), 32'd1);
    chk("bp_pops", 32'(pop_idx), 32'd0);
    rdy_mode = 2;
    for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
    chk("bp_done", 32'(done_cnt - d0), 32'd1);
    chk("bp_total_reqs", 32'(req_cnt), 32'd8);
    chk("bp_total_pops", 32'(pop_idx), 32'd8);
    chk("bp_underrun", 32'(underrun), 32'd0);

    // Frame overrun after 5 acks: stale returns dropped, frame restarts from the base
    rdy_mode = 2; stat = 1'b0; nxt_base = 24'h100; fs_next = 1'b1; req_cnt = 0;
    for (int i = 0; i < 100 && req_cnt < 5; i++) tick();
    chk("ab_acks", 32'(req_cnt), 32'd5);
    d0 = done_cnt;
    fs_next = 1'b1;
    tick();
    req_cnt = 0;
    tick();
    chk("ab_flush_req", 32'(mem_req), 32'd0);
    chk("ab_flush_valid", 32'(pix_valid), 32'd0);
    for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
    chk("ab_done_once", 32'(done_cnt - d0), 32'd1);
    chk("ab_reqs", 32'(req_cnt), 32'd8);
    chk("ab_pops", 32'(pop_idx), 32'd8);
    chk("ab_stale_drained", 32'(old_outst), 32'd0);
    chk("ab_underrun", 32'(underrun), 32'd0);

    // Directed frame table
    foreach (tbl[i]) begin
      lat = tbl[i].lat; ack_pct = tbl[i].ack_pct; vld_pct = tbl[i].vld_pct;
      rdy_mode = tbl[i].rdy_mode;
      run_frame(tbl[i].st, tbl[i].base);
      chk("tbl_underrun", 32'(underrun), 32'(tbl[i].exp_unr));
    end

    // Random stalls over many frames
    rdy_mode = 3;
    for (int f = 0; f < 100; f++) begin
      lat     = int'($urandom_range(4, 1));
      ack_pct = int'($urandom_range(100, 30));
      vld_pct = int'($urandom_range(100, 30));
      rdy_pct = int'($urandom_range(90, 20));
      s       = 1'($urandom_range(1, 0));
      run_frame(s, s ? 24'h900 : 24'h100);
    end
    chk("final_underrun", 32'(underrun), 32'd1);
    chk("final_outstanding", 32'(outst_m), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
